// File: rtl/segment_status_scanner.sv
// Four-digit 7-segment status scanner: frame-synchronous snapshots, anti-ghosting blank window, alarm blink.
// Optional heartbeat on the digit-0 decimal point when SCAN_HEARTBEAT_EN is defined.
module segment_status_scanner #(
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       slow_clock,
  input  logic [2:0] water_level,
  input  logic [2:0] system_state,
  input  logic       fertilising,
  input  logic       cleaning,
  input  logic       alarm,
  output logic [6:0] segments,
  output logic [3:0] digit_enable,
  output logic       dp
);

  localparam int CW = $clog2(SCAN_DIV);

  // Glyphs are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_F     = 7'b0001110;
  localparam logic [6:0] G_C     = 7'b1000110;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_S     = 7'b0010010;
  localparam logic [6:0] G_D     = 7'b0100001;
  localparam logic [6:0] G_A     = 7'b0001000;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [2:0]    r_level;
  logic [2:0]    r_state;
  logic          r_fert;
  logic          r_clean;
  logic          r_alarm;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync_prev;
  logic          r_blink;
  logic [6:0]    r_segments;
  logic [3:0]    r_digit_enable;
  logic          r_dp;

  logic          w_terminal;
  logic          w_in_blank;
  logic          w_tick;
  logic [6:0]    w_num;
  logic [6:0]    w_letter;
  logic [6:0]    w_activity;
  logic [6:0]    w_glyph;
  logic [6:0]    w_seg_next;
  logic [3:0]    w_en_next;
  logic          w_dp_next;

  assign w_terminal = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_in_blank = (r_cnt < CW'(BLANK_CYCLES));
  assign w_tick     = r_sync2 & ~r_sync_prev;

  // Scan timing, end-of-frame snapshot and slow_clock synchroniser.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_level     <= 3'd0;
      r_state     <= 3'd0;
      r_fert      <= 1'b0;
      r_clean     <= 1'b0;
      r_alarm     <= 1'b0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      r_sync1     <= slow_clock;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      if (w_terminal) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_level <= water_level;
          r_state <= system_state;
          r_fert  <= fertilising;
          r_clean <= cleaning;
          r_alarm <= alarm;
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (!r_alarm)
        r_blink <= 1'b0;
      else if (w_tick)
        r_blink <= ~r_blink;
    end
  end

  always_comb begin
    w_num = G_BLANK;
    case (r_level)
      3'd0: w_num = 7'b1000000;
      3'd1: w_num = 7'b1111001;
      3'd2: w_num = 7'b0100100;
      3'd3: w_num = 7'b0110000;
      3'd4: w_num = 7'b0011001;
      3'd5: w_num = 7'b0010010;
      3'd6: w_num = 7'b0000010;
      3'd7: w_num = 7'b1111000;
      default: w_num = G_BLANK;
    endcase

    w_letter = G_E;
    case (r_state)
      3'b000:  w_letter = G_DASH;
      3'b001:  w_letter = G_F;
      3'b010:  w_letter = G_C;
      3'b011:  w_letter = G_E;
      3'b100:  w_letter = G_S;
      3'b101:  w_letter = G_D;
      default: w_letter = G_E;
    endcase

    // Fertilising takes priority over cleaning on the activity digit.
    w_activity = G_BLANK;
    if (r_fert)
      w_activity = G_F;
    else if (r_clean)
      w_activity = G_C;

    w_glyph = G_BLANK;
    case (r_idx)
      2'd0:    w_glyph = w_num;
      2'd1:    w_glyph = w_letter;
      2'd2:    w_glyph = w_activity;
      default: w_glyph = r_alarm ? G_A : G_BLANK;
    endcase

    w_seg_next = r_blink ? G_BLANK : w_glyph;
    w_en_next  = w_in_blank ? 4'b1111 : ~(4'b0001 << r_idx);
  end

`ifdef SCAN_HEARTBEAT_EN
  logic r_heartbeat;

  always_ff @(posedge clock) begin
    if (reset)
      r_heartbeat <= 1'b0;
    else if (w_tick)
      r_heartbeat <= ~r_heartbeat;
  end

  assign w_dp_next = (r_idx == 2'd0 && !w_in_blank) ? ~r_heartbeat : 1'b1;
`else
  assign w_dp_next = 1'b1;
`endif

  // Outputs are registered, one cycle behind the scan state they depict.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_segments     <= G_BLANK;
      r_digit_enable <= 4'b1111;
      r_dp           <= 1'b1;
    end else begin
      r_segments     <= w_seg_next;
      r_digit_enable <= w_en_next;
      r_dp           <= w_dp_next;
    end
  end

  assign segments     = r_segments;
  assign digit_enable = r_digit_enable;
  assign dp           = r_dp;

endmodule
